// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO pointer definitions: default geometry and Gray/binary conversion,
// used by both the read-side and the write-side controllers.
package fifo_rd_ctrl_pkg;

    localparam int ADDR_DEF   = 3;
    localparam int DATA_W_DEF = 8;

    // Widest pointer the helpers handle; callers zero-extend in and truncate out.
    localparam int PTR_MAX = 16;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock.
module ptr_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-side controller: edge-triggered reads, Gray pointer, sticky underflow.
// Define FIFO_RD_AEMPTY_EN to add the raempty (almost-empty) output.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR      = ADDR_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int AEMPTY_TH = 2
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rinc,
    input  logic [ADDR:0]     wptr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR-1:0]   raddr,
    output logic [ADDR:0]     rptr,
    output logic              rempty,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
`ifdef FIFO_RD_AEMPTY_EN
    output logic              raempty,
`endif
    output logic              rerr
);

    localparam int PW = ADDR + 1;

    if (AEMPTY_TH < 0 || AEMPTY_TH > (1 << ADDR) - 1) begin : g_bad_th
        $error("fifo_rd_ctrl: AEMPTY_TH out of range 0..2^ADDR-1");
    end

    logic [ADDR:0]     rq2_wptr;
    logic [ADDR:0]     rbin_q, rbin_d, rbin_nxt;
    logic [ADDR-1:0]   raddr_q, raddr_d;
    logic [ADDR:0]     rptr_q, rptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic              rinc_dly_q, rinc_dly_d;
    logic              rd_pulse, accept, empty;

    ptr_sync #(.W(PW)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (rq2_wptr)
    );

    // Empty is decided purely from flops, so a write landing this cycle waits one more.
    assign empty    = (rptr_q == rq2_wptr);
    assign rd_pulse = rinc & ~rinc_dly_q;
    assign accept   = rd_pulse & ~empty;
    assign rbin_nxt = rbin_q + PW'(1);

    always_comb begin
        rinc_dly_d = rinc;
        rbin_d     = rbin_q;
        raddr_d    = raddr_q;
        rptr_d     = rptr_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        rerr_d     = rerr_q;
        if (accept) begin
            rbin_d   = rbin_nxt;
            raddr_d  = rbin_nxt[ADDR-1:0];
            rptr_d   = PW'(bin2gray(PTR_MAX'(rbin_nxt)));
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
        end else if (rd_pulse) begin
            rerr_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rinc_dly_q <= 1'b0;
            rbin_q     <= '0;
            raddr_q    <= '0;
            rptr_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            rinc_dly_q <= rinc_dly_d;
            rbin_q     <= rbin_d;
            raddr_q    <= raddr_d;
            rptr_q     <= rptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
        end
    end

`ifdef FIFO_RD_AEMPTY_EN
    logic [ADDR:0] wbin_sync;
    logic [ADDR:0] occupancy;

    // Modular subtraction gives the correct count across pointer wrap.
    assign wbin_sync = PW'(gray2bin(PTR_MAX'(rq2_wptr)));
    assign occupancy = wbin_sync - rbin_q;
    assign raempty   = (occupancy <= PW'(AEMPTY_TH));
`endif

    assign raddr  = raddr_q;
    assign rptr   = rptr_q;
    assign rempty = empty;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rerr   = rerr_q;

endmodule
